sgdmac_wr_engine: RTL and testbench

SGDMAC_WR_ENGINE -- requirements
Module: sgdmac_wr_engine

---
 rtl/sgdmac_pkg.sv | 36 +++
 rtl/sgdmac_wr_engine.sv | 189 ++++++++++++++++++
 tb/tb_sgdmac_wr_engine.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sgdmac_pkg.sv
// -----------------------------------------------------------------------------
// sgdmac_pkg
// Shared definitions for the scatter-gather DMA write engine:
//   state_e        - write-engine FSM states
//   AXI_RESP_OKAY  - AXI BRESP value for a good write response
//   PAGE_BYTES     - AXI 4 KB page size; bursts never cross it
//   burst_beats()  - beats for the next burst from the burst limit, the words
//                    still to send and the offset inside the current page
// -----------------------------------------------------------------------------
package sgdmac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } state_e;

  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
  localparam logic [31:0] PAGE_BYTES    = 32'd4096;

  // min(max_beats, rem_words, words left before the next 4 KB boundary).
  // page_off is word aligned, so the room is an exact word count (1..1024).
  function automatic logic [4:0] burst_beats(input logic [4:0]  max_beats,
                                             input logic [31:0] rem_words,
                                             input logic [11:0] page_off);
    logic [31:0] room;
    logic [31:0] n;
    room = (PAGE_BYTES - {20'd0, page_off}) >> 2;
    n    = {27'd0, max_beats};
    if (rem_words < n) n = rem_words;
    if (room < n)      n = room;
    return 5'(n);
  endfunction

endpackage

// File: rtl/sgdmac_wr_engine.sv
// -----------------------------------------------------------------------------
// sgdmac_wr_engine
// Moves one job of byte_len_i bytes from an upstream show-ahead FIFO to AXI
// memory starting at dst_addr_i, as a sequence of INCR bursts of 4-byte beats
// that never cross a 4 KB page. AW, W and B are strictly serialized: one
// burst in flight, and its data only after its address handshake.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   start_i, dst_addr_i, byte_len_i job request (taken only in IDLE)
//   busy_o, done_o, err_o           job status; done_o pulses once per job
//   fifo_empty_i, fifo_rden_o,
//   fifo_rdata_i                    upstream data FIFO (show-ahead)
//   aw*/w*/b*                       AXI write address / data / response
//
// Configuration
//   SGDMAC_WR_BRESP_CHK_EN  when defined, a non-OKAY BRESP sets err_o and ends
//                           the job after that burst; otherwise BRESP is
//                           ignored and err_o is tied low.
// -----------------------------------------------------------------------------
module sgdmac_wr_engine
  import sgdmac_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [LEN_WIDTH-1:0]  byte_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rden_o,
  input  logic [31:0]           fifo_rdata_i,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [ADDR_WIDTH-1:0] awaddr_o,
  output logic [3:0]            awlen_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  output logic [31:0]           wdata_o,
  output logic                  wlast_o,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  input  logic [1:0]            bresp_i
);

  localparam int WORDS_W = LEN_WIDTH - 2;

  state_e                r_state;
  state_e                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;        // address of the current/next burst
  logic [WORDS_W-1:0]    r_rem_words;   // words not yet acknowledged by B
  logic [4:0]            r_beats;       // beats in the current burst
  logic [4:0]            r_beat_idx;    // W beats already sent in this burst
  logic [3:0]            r_awlen;
  logic                  r_awvalid;
  logic                  r_done;

  logic [WORDS_W-1:0]    w_len_words;
  logic [WORDS_W-1:0]    w_rem_after;
  logic [4:0]            w_beats_calc;
  logic                  w_accept;
  logic                  w_aw_hs;
  logic                  w_wvalid;
  logic                  w_wlast;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_bresp_err;
  logic                  w_job_end;
  logic                  w_unused;

  assign w_len_words  = byte_len_i[LEN_WIDTH-1:2];
  assign w_accept     = (r_state == ST_IDLE) && start_i;
  assign w_aw_hs      = r_awvalid && awready_i;
  assign w_wvalid     = (r_state == ST_W) && !fifo_empty_i;
  assign w_wlast      = w_wvalid && (r_beat_idx == r_beats - 5'd1);
  assign w_w_hs       = w_wvalid && wready_i;
  assign w_b_hs       = (r_state == ST_B) && bvalid_i;
  assign w_rem_after  = r_rem_words - WORDS_W'(r_beats);
  assign w_beats_calc = burst_beats(5'(MAX_BURST), 32'(r_rem_words), r_addr[11:0]);

`ifdef SGDMAC_WR_BRESP_CHK_EN
  logic r_err;

  assign w_bresp_err = (bresp_i != AXI_RESP_OKAY);
  assign w_unused    = ^byte_len_i[1:0];
  assign err_o       = r_err;

  // Sticky per job: cleared when the next job is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_b_hs && w_bresp_err) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_bresp_err = 1'b0;
  assign w_unused    = ^{byte_len_i[1:0], bresp_i};
  assign err_o       = 1'b0;
`endif

  // An error response ends the job exactly like the last burst does.
  assign w_job_end = (w_rem_after == '0) || w_bresp_err;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the next state gets its default before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start_i && (w_len_words != '0)) w_state_next = ST_AW;
      ST_AW:   if (w_aw_hs)                        w_state_next = ST_W;
      ST_W:    if (w_w_hs && w_wlast)              w_state_next = ST_B;
      ST_B:    if (bvalid_i)                       w_state_next = w_job_end ? ST_IDLE : ST_AW;
      default:                                     w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_rem_words <= '0;
      r_beats     <= '0;
      r_beat_idx  <= '0;
      r_awlen     <= '0;
      r_awvalid   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_accept) begin
        r_addr      <= dst_addr_i;
        r_rem_words <= w_len_words;
        // An empty job completes without entering AW.
        if (w_len_words == '0) r_done <= 1'b1;
      end

      // First AW cycle sizes the burst from the registered address/remaining
      // count; awvalid then rises and holds until the handshake.
      if ((r_state == ST_AW) && !r_awvalid) begin
        r_beats   <= w_beats_calc;
        r_awlen   <= 4'(w_beats_calc - 5'd1);
        r_awvalid <= 1'b1;
      end else if (w_aw_hs) begin
        r_awvalid <= 1'b0;
      end

      if (w_w_hs) begin
        r_beat_idx <= w_wlast ? 5'd0 : r_beat_idx + 5'd1;
      end

      if (w_b_hs) begin
        // Address wraps naturally modulo 2^ADDR_WIDTH.
        r_addr      <= r_addr + ADDR_WIDTH'({r_beats, 2'b00});
        r_rem_words <= w_job_end ? '0 : w_rem_after;
        if (w_job_end) r_done <= 1'b1;
      end
    end
  end

  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = r_done;
  assign awvalid_o   = r_awvalid;
  assign awaddr_o    = r_addr;
  assign awlen_o     = r_awlen;
  assign wvalid_o    = w_wvalid;
  assign wdata_o     = (r_state == ST_W) ? fifo_rdata_i : 32'd0;
  assign wlast_o     = w_wlast;
  assign fifo_rden_o = w_w_hs;
  assign bready_o    = (r_state == ST_B);

endmodule

// File: tb/tb_sgdmac_wr_engine.sv
module tb_sgdmac_wr_engine;

  localparam int AW   = 32;
  localparam int LW   = 16;
  localparam int MAXB = 16;
`ifdef SGDMAC_WR_BRESP_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [AW-1:0] dst_addr_i;
  logic [LW-1:0] byte_len_i;
  logic          busy_o, done_o, err_o;
  logic          fifo_empty_i, fifo_rden_o;
  logic [31:0]   fifo_rdata_i;
  logic          awvalid_o, awready_i;
  logic [AW-1:0] awaddr_o;
  logic [3:0]    awlen_o;
  logic          wvalid_o, wready_i, wlast_o;
  logic [31:0]   wdata_o;
  logic          bvalid_i, bready_o;
  logic [1:0]    bresp_i;

  sgdmac_wr_engine #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_i(start_i), .dst_addr_i(dst_addr_i), .byte_len_i(byte_len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .fifo_empty_i(fifo_empty_i), .fifo_rden_o(fifo_rden_o), .fifo_rdata_i(fifo_rdata_i),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o), .awlen_o(awlen_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wlast_o(wlast_o),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
  } aw_t;

  typedef struct {
    logic [31:0] addr;
    int          len;
    int          nb;
    logic [31:0] a0;
    logic [3:0]  l0;
    logic [31:0] an;
    logic [3:0]  ln;
  } vec_t;

  aw_t         aw_log[$];
  aw_t         exp_aw[$];
  logic [31:0] fifo_q[$];
  logic [31:0] data_src[$];
  logic [31:0] wd_log[$];
  bit          wl_log[$];
  logic [1:0]  resp_q[$];
  logic [1:0]  resp_plan[$];
  vec_t        vecs[8];

  int aw_ready_pct = 100, w_ready_pct = 100, empty_pct = 0, b_delay_max = 0;
  int gap_at = -1, gap_len = 0, gap_left = 0, pops = 0, done_cnt = 0, b_wait = 0;
  bit in_gap, b_pending, aw_outstanding, aw_wait, noise_en, start_force, exp_err;
  logic [31:0] job_addr, hold_addr;
  logic [15:0] job_len;
  logic [3:0]  hold_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment: FIFO, AXI slave and start noise. Inputs change at negedge.
  task automatic drive_inputs();
    in_gap = (gap_left > 0);
    if (gap_left > 0) gap_left--;
    fifo_empty_i = in_gap || (fifo_q.size() == 0) || (int'($urandom_range(99)) < empty_pct);
    fifo_rdata_i = (fifo_q.size() != 0) ? fifo_q[0] : $urandom;
    awready_i    = (int'($urandom_range(99)) < aw_ready_pct);
    wready_i     = (int'($urandom_range(99)) < w_ready_pct);
    bvalid_i     = 1'b0;
    bresp_i      = 2'b00;
    if (b_pending) begin
      if (b_wait == 0) begin
        bvalid_i = 1'b1;
        bresp_i  = (resp_q.size() != 0) ? resp_q[0] : 2'b00;
      end else begin
        b_wait--;
      end
    end
    if (start_force) begin
      start_i    = 1'b1;
      dst_addr_i = job_addr;
      byte_len_i = job_len;
    end else begin
      // Spurious requests only while busy: they must be ignored.
      start_i    = noise_en && busy_o && ($urandom_range(1) == 1);
      dst_addr_i = $urandom;
      byte_len_i = 16'($urandom) & 16'hFFFC;
    end
  endtask

  // Observe the cycle's settled outputs; handshakes take effect at posedge.
  task automatic observe();
    if (in_gap) begin
      check("gap_wvalid", wvalid_o, 0);
      check("gap_rden", fifo_rden_o, 0);
    end
    if (wvalid_o || fifo_rden_o) begin
      check("rden_rule", fifo_rden_o, wvalid_o & wready_i);
      check("wvalid_not_empty", fifo_empty_i, 0);
      check("wdata_head", wdata_o, fifo_rdata_i);
      check("w_after_aw", aw_outstanding, 1);
    end
    if (aw_wait) begin
      check("aw_hold_valid", awvalid_o, 1);
      check("aw_hold_addr", awaddr_o, hold_addr);
      check("aw_hold_len", awlen_o, hold_len);
    end
    aw_wait = 1'b0;
    if (awvalid_o) begin
      if (awready_i) begin
        check("aw_one_outstanding", aw_outstanding, 0);
        aw_log.push_back('{awaddr_o, awlen_o});
        aw_outstanding = 1'b1;
      end else begin
        aw_wait   = 1'b1;
        hold_addr = awaddr_o;
        hold_len  = awlen_o;
      end
    end
    if (wvalid_o && wready_i) begin
      wd_log.push_back(wdata_o);
      wl_log.push_back(wlast_o);
      if (fifo_q.size() != 0) fifo_q.delete(0);
      pops++;
      if (pops == gap_at) begin
        gap_left = gap_len;
        gap_at   = -1;
      end
      if (wlast_o) begin
        b_pending = 1'b1;
        b_wait    = int'($urandom_range(b_delay_max));
      end
    end
    if (bvalid_i) begin
      check("bready", bready_o, 1);
      if (bready_o) begin
        b_pending      = 1'b0;
        aw_outstanding = 1'b0;
        if (resp_q.size() != 0) resp_q.delete(0);
      end
    end
    if (done_o) begin
      done_cnt++;
      check("done_busy_low", busy_o, 0);
    end
  endtask

  task automatic step();
    drive_inputs();
    #1;
    observe();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: walk the job in bursts of min(limit, remaining, page room).
  task automatic build_expect(input logic [31:0] addr, input int words);
    logic [31:0] a;
    int rem, b, room, k;
    a = addr; rem = words; k = 0;
    exp_aw.delete();
    exp_err = 1'b0;
    while (rem > 0) begin
      room = (4096 - int'(a % 32'd4096)) / 4;
      b = MAXB;
      if (rem < b)  b = rem;
      if (room < b) b = room;
      exp_aw.push_back('{a, 4'(b - 1)});
      a   = a + 32'(4 * b);
      rem = rem - b;
      if (CHK_EN && (k < resp_plan.size()) && (resp_plan[k] != 2'b00)) begin
        exp_err = 1'b1;
        rem     = 0;
      end
      k++;
    end
  endtask

  task automatic run_job(input logic [31:0] addr, input logic [15:0] len, input string tag);
    int words, cyc, nbeats, idx;
    words = int'(len) / 4;
    aw_log.delete(); wd_log.delete(); wl_log.delete(); fifo_q.delete();
    done_cnt = 0; pops = 0;
    resp_q = resp_plan;
    for (int i = 0; i < words; i++) fifo_q.push_back($urandom);
    data_src = fifo_q;
    build_expect(addr, words);
    job_addr = addr; job_len = len; start_force = 1'b1;
    step();
    start_force = 1'b0;
    if (words == 0) begin
      check({tag, ":len0_done"}, done_o, 1);
      check({tag, ":len0_busy"}, busy_o, 0);
    end else begin
      check({tag, ":busy"}, busy_o, 1);
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      step();
      cyc++;
    end
    check({tag, ":finished"}, done_cnt != 0, 1);
    repeat (3) step();
    check({tag, ":done_once"}, done_cnt, 1);
    check({tag, ":aw_count"}, aw_log.size(), exp_aw.size());
    for (int i = 0; i < exp_aw.size() && i < aw_log.size(); i++) begin
      check({tag, ":awaddr"}, aw_log[i].addr, exp_aw[i].addr);
      check({tag, ":awlen"}, aw_log[i].len, exp_aw[i].len);
    end
    nbeats = 0;
    foreach (exp_aw[i]) nbeats += int'(exp_aw[i].len) + 1;
    check({tag, ":beats"}, wd_log.size(), nbeats);
    check({tag, ":pops"}, pops, nbeats);
    idx = 0;
    foreach (exp_aw[k]) begin
      for (int j = 0; j <= int'(exp_aw[k].len); j++) begin
        if (idx < wd_log.size()) begin
          check({tag, ":wdata"}, wd_log[idx], data_src[idx]);
          check({tag, ":wlast"}, wl_log[idx], j == int'(exp_aw[k].len));
        end
        idx++;
      end
    end
    check({tag, ":err"}, err_o, exp_err);
    check({tag, ":idle"}, busy_o, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] ra;
    rst_n = 1'b0; start_i = 1'b0; dst_addr_i = '0; byte_len_i = '0;
    fifo_empty_i = 1'b1; fifo_rdata_i = '0; awready_i = 1'b0; wready_i = 1'b0;
    bvalid_i = 1'b0; bresp_i = 2'b00;

    //           addr            len  nb  first addr      len    last addr       len
    vecs[0] = '{32'h0000_1000,  64, 1, 32'h0000_1000, 4'd15, 32'h0000_1000, 4'd15};
    vecs[1] = '{32'h0000_0FF8,  32, 2, 32'h0000_0FF8, 4'd1,  32'h0000_1000, 4'd5};
    vecs[2] = '{32'h0000_2000,   4, 1, 32'h0000_2000, 4'd0,  32'h0000_2000, 4'd0};
    vecs[3] = '{32'h0000_3000, 128, 2, 32'h0000_3000, 4'd15, 32'h0000_3040, 4'd15};
    vecs[4] = '{32'h0000_4FFC,   8, 2, 32'h0000_4FFC, 4'd0,  32'h0000_5000, 4'd0};
    vecs[5] = '{32'hFFFF_FFF8,  16, 2, 32'hFFFF_FFF8, 4'd1,  32'h0000_0000, 4'd1};
    vecs[6] = '{32'h0000_1040, 100, 2, 32'h0000_1040, 4'd15, 32'h0000_1080, 4'd8};
    vecs[7] = '{32'h0000_0FC0,  80, 2, 32'h0000_0FC0, 4'd15, 32'h0000_1000, 4'd3};

    repeat (3) @(negedge clk);
    check("rst:busy", busy_o, 0);
    check("rst:done", done_o, 0);
    check("rst:err", err_o, 0);
    check("rst:awvalid", awvalid_o, 0);
    check("rst:awaddr", awaddr_o, 0);
    check("rst:awlen", awlen_o, 0);
    check("rst:wvalid", wvalid_o, 0);
    check("rst:wlast", wlast_o, 0);
    check("rst:rden", fifo_rden_o, 0);
    check("rst:bready", bready_o, 0);
    rst_n = 1'b1;
    step();

    // Directed table: burst splitting, page boundaries, address wrap.
    for (int i = 0; i < 8; i++) begin
      aw_ready_pct = (i % 2 == 1) ? 60 : 100;
      w_ready_pct  = (i % 2 == 1) ? 60 : 100;
      b_delay_max  = i % 3;
      run_job(vecs[i].addr, 16'(vecs[i].len), $sformatf("vec%0d", i));
      check($sformatf("vec%0d:nb", i), aw_log.size(), vecs[i].nb);
      if (aw_log.size() != 0) begin
        check($sformatf("vec%0d:a0", i), aw_log[0].addr, vecs[i].a0);
        check($sformatf("vec%0d:l0", i), aw_log[0].len, vecs[i].l0);
        check($sformatf("vec%0d:an", i), aw_log[aw_log.size()-1].addr, vecs[i].an);
        check($sformatf("vec%0d:ln", i), aw_log[aw_log.size()-1].len, vecs[i].ln);
      end
    end

    // Zero-length job.
    aw_ready_pct = 100; w_ready_pct = 100; b_delay_max = 0;
    run_job(32'h0000_9000, 16'd0, "len0");
    check("len0:no_aw", aw_log.size(), 0);

    // FIFO runs dry for 5 cycles after the 5th pop.
    gap_at = 5; gap_len = 5;
    run_job(32'h0000_8000, 16'd64, "gap");
    gap_at = -1;

    // Error response on the first of three bursts.
    resp_plan.delete();
    resp_plan.push_back(2'b10); resp_plan.push_back(2'b00); resp_plan.push_back(2'b00);
    run_job(32'h0000_6000, 16'd192, "bresp");
    check("bresp:aw_count", aw_log.size(), CHK_EN ? 1 : 3);
    check("bresp:err_flag", err_o, CHK_EN);
    resp_plan.delete();
    run_job(32'h0000_6100, 16'd8, "err_clear");

    // Reset in the middle of a W burst.
    fifo_q.delete();
    for (int i = 0; i < 16; i++) fifo_q.push_back($urandom);
    job_addr = 32'h0000_7000; job_len = 16'd64; start_force = 1'b1;
    step();
    start_force = 1'b0;
    cyc = 0;
    while (!wvalid_o && cyc < 50) begin
      step();
      cyc++;
    end
    check("midrst:reached_w", wvalid_o, 1);
    done_cnt = 0;
    rst_n = 1'b0;
    #1;
    check("midrst:busy", busy_o, 0);
    check("midrst:done", done_o, 0);
    check("midrst:awvalid", awvalid_o, 0);
    check("midrst:awaddr", awaddr_o, 0);
    check("midrst:awlen", awlen_o, 0);
    check("midrst:wvalid", wvalid_o, 0);
    check("midrst:wdata", wdata_o, 0);
    check("midrst:wlast", wlast_o, 0);
    check("midrst:rden", fifo_rden_o, 0);
    check("midrst:bready", bready_o, 0);
    step();
    step();
    check("midrst:no_done", done_cnt, 0);
    rst_n = 1'b1;
    b_pending = 1'b0; aw_outstanding = 1'b0; aw_wait = 1'b0;
    fifo_q.delete(); resp_q.delete();
    step();
    check("midrst:idle", busy_o, 0);

    // Randomized jobs with backpressure, FIFO bubbles and start noise.
    noise_en = 1'b1;
    for (int n = 0; n < 30; n++) begin
      ra = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(1) == 1) ra[11:0] = 12'hFFC - 12'(4 * $urandom_range(20));
      aw_ready_pct = 30 + int'($urandom_range(70));
      w_ready_pct  = 30 + int'($urandom_range(70));
      empty_pct    = int'($urandom_range(30));
      b_delay_max  = int'($urandom_range(3));
      run_job(ra, 16'(4 * $urandom_range(70)), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
